hilo_mdu: RTL and testbench

//  Multi-cycle multiply/divide unit that produces HI/LO results for MIPS

---
 rtl/hilo_mdu.sv | 263 ++++++++++++++++++++++++++
 tb/tb_hilo_mdu.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu.sv
// hilo_mdu: multi-cycle MIPS multiply/divide unit feeding the HI/LO file.
// Ports: clk, rst (sync, active-high), start/op/src_a/src_b/flush in;
//   stall_o, hi_o, lo_o, we_hi, we_lo, we_hilo, done_o out.
// Build option: HILO_MDU_FAST_MUL_EN selects a single-cycle multiplier.
module hilo_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             we_hi,
  output logic             we_lo,
  output logic             we_hilo,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_q, neg_d;
  logic             sa_q, sa_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we_hi_q, we_hi_d;
  logic             we_lo_q, we_lo_d;
  logic             we_hilo_q, we_hilo_d;
  logic             done_q, done_d;

  // Operand magnitudes; unsigned ops keep the raw bits.
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = is_signed & src_a[WIDTH-1];
  assign b_neg     = is_signed & src_b[WIDTH-1];
  assign mag_a     = a_neg ? -src_a : src_a;
  assign mag_b     = b_neg ? -src_b : src_b;

  // One iteration step. Divide keeps {rem, quotient/dividend} in
  // acc_hi/acc_lo; multiply keeps {partial product, multiplier}.
  logic             q_div;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_lo;

  assign q_div    = op_q[1];
  assign div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign mul_sum  = {1'b0, acc_hi_q}
                  + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

  assign it_hi = q_div
               ? (div_diff[WIDTH] ? div_sh[WIDTH-1:0]
                                  : div_diff[WIDTH-1:0])
               : mul_sum[WIDTH:1];
  assign it_lo = q_div
               ? {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]}
               : {mul_sum[0], acc_lo_q[WIDTH-1:1]};

  // Sign fix-up on the final iteration result.
  logic [2*WIDTH-1:0] it_prod;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;

  assign it_prod = {it_hi, it_lo};
  assign mul_res = neg_q ? -it_prod : it_prod;
  assign quo_res = neg_q ? -it_lo : it_lo;
  assign rem_res = sa_q ? -it_hi : it_hi;

`ifdef HILO_MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] f_prod;
  logic [2*WIDTH-1:0] f_res;

  assign f_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
  assign f_res  = (a_neg ^ b_neg) ? -f_prod : f_prod;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    sa_d      = sa_q;
    cnt_d     = cnt_q;
    we_hi_d   = 1'b0;
    we_lo_d   = 1'b0;
    we_hilo_d = 1'b0;
    done_d    = 1'b0;
    stall_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MTHI: begin
              hi_d    = src_a;
              we_hi_d = 1'b1;
              done_d  = 1'b1;
              state_d = DONE;
            end
            OP_MTLO: begin
              lo_d    = src_a;
              we_lo_d = 1'b1;
              done_d  = 1'b1;
              state_d = DONE;
            end
            OP_MULT, OP_MULTU: begin
`ifdef HILO_MDU_FAST_MUL_EN
              hi_d      = f_res[2*WIDTH-1:WIDTH];
              lo_d      = f_res[WIDTH-1:0];
              we_hilo_d = 1'b1;
              done_d    = 1'b1;
              state_d   = DONE;
`else
              op_d     = op;
              opnd_d   = mag_a;
              acc_hi_d = '0;
              acc_lo_d = mag_b;
              neg_d    = a_neg ^ b_neg;
              cnt_d    = '0;
              stall_o  = 1'b1;
              state_d  = CALC;
`endif
            end
            OP_DIV, OP_DIVU: begin
              if (src_b == '0) begin
                hi_d      = src_a;
                lo_d      = '1;
                we_hilo_d = 1'b1;
                done_d    = 1'b1;
                state_d   = DONE;
              end else begin
                op_d     = op;
                opnd_d   = mag_b;
                acc_hi_d = '0;
                acc_lo_d = mag_a;
                neg_d    = a_neg ^ b_neg;
                sa_d     = a_neg;
                cnt_d    = '0;
                stall_o  = 1'b1;
                state_d  = CALC;
              end
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        stall_o  = 1'b1;
        acc_hi_d = it_hi;
        acc_lo_d = it_lo;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          if (q_div) begin
            hi_d = rem_res;
            lo_d = quo_res;
          end else begin
            hi_d = mul_res[2*WIDTH-1:WIDTH];
            lo_d = mul_res[WIDTH-1:0];
          end
          we_hilo_d = 1'b1;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort: nothing from this op may reach HI/LO.
    if (flush) begin
      state_d   = IDLE;
      hi_d      = hi_q;
      lo_d      = lo_q;
      we_hi_d   = 1'b0;
      we_lo_d   = 1'b0;
      we_hilo_d = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      sa_q      <= 1'b0;
      cnt_q     <= '0;
      we_hi_q   <= 1'b0;
      we_lo_q   <= 1'b0;
      we_hilo_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      sa_q      <= sa_d;
      cnt_q     <= cnt_d;
      we_hi_q   <= we_hi_d;
      we_lo_q   <= we_lo_d;
      we_hilo_q <= we_hilo_d;
      done_q    <= done_d;
    end
  end

  // A flush landing in the DONE cycle still kills the write.
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign we_hi   = we_hi_q & ~flush;
  assign we_lo   = we_lo_q & ~flush;
  assign we_hilo = we_hilo_q & ~flush;
  assign done_o  = done_q & ~flush;

endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: scoreboard bench for hilo_mdu.
// Expected results are queued at issue and popped at done_o.
module tb_hilo_mdu;

  localparam logic [2:0] MULT  = 3'd0;
  localparam logic [2:0] MULTU = 3'd1;
  localparam logic [2:0] DIV   = 3'd2;
  localparam logic [2:0] DIVU  = 3'd3;
  localparam logic [2:0] MTHI  = 3'd4;
  localparam logic [2:0] MTLO  = 3'd5;

`ifdef HILO_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [2:0]  we;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        we_hi;
  logic        we_lo;
  logic        we_hilo;
  logic        done_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  vec_t        sb[$];
  logic [31:0] mdl_hi;
  logic [31:0] mdl_lo;

  hilo_mdu #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .flush   (flush),
    .stall_o (stall_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .we_hi   (we_hi),
    .we_lo   (we_lo),
    .we_hilo (we_hilo),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  // Drive one op, queue its expectation, wait (bounded) for done_o.
  task automatic issue(input vec_t v, output int lat,
                       output bit to, output int nst);
    @(posedge clk); #1;
    op = v.op; src_a = v.a; src_b = v.b; start = 1'b1;
    sb.push_back(v);
    #1 nst = int'(stall_o);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    lat = 1; to = 1'b0;
    while (done_o !== 1'b1) begin
      if (lat >= 200) begin
        to = 1'b1;
        break;
      end
      nst += int'(stall_o);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    int hits;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    op = 3'd0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({hi_o, lo_o, we_hi, we_lo, we_hilo, done_o, stall_o} !== '0) begin
      n_bad++;
      $display("FAIL reset: got hi=%h lo=%h we=%b done=%b stall=%b, want all 0",
               hi_o, lo_o, {we_hi, we_lo, we_hilo}, done_o, stall_o);
    end
    rst = 1'b0;
    mdl_hi = '0; mdl_lo = '0;
    // op 6 is not an instruction for this unit
    @(posedge clk); #1;
    op = 3'd6; src_a = 32'h55; start = 1'b1;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_bad++;
      $display("FAIL op6_stall: got %b, want 0", stall_o);
    end
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    hits = 0;
    repeat (3) begin
      if ((done_o | we_hi | we_lo | we_hilo) !== 1'b0) hits++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (hits != 0) begin
      n_bad++;
      $display("FAIL op6_ignored: got %0d strobe cycles, want 0", hits);
    end
  endtask

  task automatic test_divide();
    vec_t v[5];
    vec_t e;
    int   lat, nst;
    bit   to;
    v[0] = '{DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 3'b001, 33};
    v[1] = '{DIV, 32'hFFFF_FFF9, 32'd2,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, 3'b001, 33};
    v[2] = '{DIV, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h0, 32'h8000_0000, 3'b001, 33};
    v[3] = '{DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 3'b001, 1};
    v[4] = '{DIV, 32'hFFFF_FFFB, 32'd0,
             32'hFFFF_FFFB, 32'hFFFF_FFFF, 3'b001, 1};
    for (int i = 0; i < 5; i++) begin
      issue(v[i], lat, to, nst);
      e = sb.pop_front();
      n_cmp++;
      if (to || {hi_o, lo_o, we_hi, we_lo, we_hilo} !== {e.hi, e.lo, e.we}) begin
        n_bad++;
        $display("FAIL div[%0d]: got hi=%h lo=%h we=%b to=%b, want hi=%h lo=%h we=%b",
                 i, hi_o, lo_o, {we_hi, we_lo, we_hilo}, to, e.hi, e.lo, e.we);
      end
      n_cmp++;
      if (lat != e.lat) begin
        n_bad++;
        $display("FAIL div_lat[%0d]: got %0d, want %0d", i, lat, e.lat);
      end
      n_cmp++;
      if (nst != ((e.lat > 1) ? e.lat : 0)) begin
        n_bad++;
        $display("FAIL div_stall[%0d]: got %0d, want %0d",
                 i, nst, (e.lat > 1) ? e.lat : 0);
      end
      mdl_hi = e.hi; mdl_lo = e.lo;
      if (i == 0) begin
        @(posedge clk); #1;
        n_cmp++;
        if ({done_o, we_hi, we_lo, we_hilo, stall_o} !== 5'b0) begin
          n_bad++;
          $display("FAIL done_pulse: got done=%b we=%b stall=%b, want 0",
                   done_o, {we_hi, we_lo, we_hilo}, stall_o);
        end
      end
    end
  endtask

  task automatic test_multiply();
    vec_t v[3];
    vec_t e;
    int   lat, nst;
    bit   to;
    v[0] = '{MULT, 32'hFFFF_FFFD, 32'd5,
             32'hFFFF_FFFF, 32'hFFFF_FFF1, 3'b001, MUL_LAT};
    v[1] = '{MULTU, 32'hFFFF_FFFF, 32'd2,
             32'd1, 32'hFFFF_FFFE, 3'b001, MUL_LAT};
    v[2] = '{MULT, 32'h8000_0000, 32'h8000_0000,
             32'h4000_0000, 32'h0, 3'b001, MUL_LAT};
    for (int i = 0; i < 3; i++) begin
      issue(v[i], lat, to, nst);
      e = sb.pop_front();
      n_cmp++;
      if (to || {hi_o, lo_o, we_hi, we_lo, we_hilo} !== {e.hi, e.lo, e.we}) begin
        n_bad++;
        $display("FAIL mul[%0d]: got hi=%h lo=%h we=%b to=%b, want hi=%h lo=%h we=%b",
                 i, hi_o, lo_o, {we_hi, we_lo, we_hilo}, to, e.hi, e.lo, e.we);
      end
      n_cmp++;
      if (lat != e.lat) begin
        n_bad++;
        $display("FAIL mul_lat[%0d]: got %0d, want %0d", i, lat, e.lat);
      end
      n_cmp++;
      if (nst != ((e.lat > 1) ? e.lat : 0)) begin
        n_bad++;
        $display("FAIL mul_stall[%0d]: got %0d, want %0d",
                 i, nst, (e.lat > 1) ? e.lat : 0);
      end
      mdl_hi = e.hi; mdl_lo = e.lo;
    end
  endtask

  task automatic test_mthi_mtlo();
    vec_t v[2];
    vec_t e;
    int   lat, nst;
    bit   to;
    v[0] = '{MTHI, 32'h1234_5678, 32'hDEAD,
             32'h1234_5678, mdl_lo, 3'b100, 1};
    v[1] = '{MTLO, 32'h0000_CAFE, 32'hBEEF,
             32'h1234_5678, 32'h0000_CAFE, 3'b010, 1};
    for (int i = 0; i < 2; i++) begin
      issue(v[i], lat, to, nst);
      e = sb.pop_front();
      n_cmp++;
      if (to || {hi_o, lo_o, we_hi, we_lo, we_hilo} !== {e.hi, e.lo, e.we}) begin
        n_bad++;
        $display("FAIL mt[%0d]: got hi=%h lo=%h we=%b to=%b, want hi=%h lo=%h we=%b",
                 i, hi_o, lo_o, {we_hi, we_lo, we_hilo}, to, e.hi, e.lo, e.we);
      end
      n_cmp++;
      if (lat != 1 || nst != 0 || stall_o !== 1'b0) begin
        n_bad++;
        $display("FAIL mt_timing[%0d]: got lat=%0d stall_cycles=%0d, want lat=1 stall_cycles=0",
                 i, lat, nst);
      end
      mdl_hi = e.hi; mdl_lo = e.lo;
    end
  endtask

  task automatic test_back_to_back();
    vec_t        v;
    vec_t        e;
    int          lat, nst;
    bit          to;
    int          ia, ib;
    longint      la, lb;
    logic [63:0] p;
    for (int i = 0; i < 8; i++) begin
      v.a  = $urandom;
      v.b  = $urandom;
      v.we = 3'b001;
      if (i < 4) v.b = v.b >> $urandom_range(0, 28);
      if (v.b == 0) v.b = 32'd3;
      case ($urandom_range(0, 3))
        0: v.op = MULT;
        1: v.op = MULTU;
        2: v.op = DIV;
        default: v.op = DIVU;
      endcase
      if (v.op == DIV && v.a == 32'h8000_0000 && v.b == '1) v.b = 32'd2;
      ia = v.a; ib = v.b;
      la = ia; lb = ib;
      case (v.op)
        MULT: begin
          p = la * lb;
          v.hi = p[63:32]; v.lo = p[31:0]; v.lat = MUL_LAT;
        end
        MULTU: begin
          p = {32'b0, v.a} * {32'b0, v.b};
          v.hi = p[63:32]; v.lo = p[31:0]; v.lat = MUL_LAT;
        end
        DIV: begin
          v.lo = ia / ib; v.hi = ia % ib; v.lat = 33;
        end
        default: begin
          v.lo = v.a / v.b; v.hi = v.a % v.b; v.lat = 33;
        end
      endcase
      issue(v, lat, to, nst);
      e = sb.pop_front();
      n_cmp++;
      if (to || {hi_o, lo_o, we_hi, we_lo, we_hilo} !== {e.hi, e.lo, e.we}
          || lat != e.lat) begin
        n_bad++;
        $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h we=%b lat=%0d, want hi=%h lo=%h we=%b lat=%0d",
                 i, e.op, e.a, e.b, hi_o, lo_o, {we_hi, we_lo, we_hilo},
                 lat, e.hi, e.lo, e.we, e.lat);
      end
      mdl_hi = e.hi; mdl_lo = e.lo;
    end
  endtask

  task automatic test_flush();
    vec_t v;
    vec_t e;
    int   lat, nst, hits;
    bit   to;
    @(posedge clk); #1;
    op = DIVU; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_stall: got %b, want 0", stall_o);
    end
    hits = 0;
    repeat (40) begin
      if ((we_hi | we_lo | we_hilo | done_o | stall_o) !== 1'b0) hits++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (hits != 0 || hi_o !== mdl_hi || lo_o !== mdl_lo) begin
      n_bad++;
      $display("FAIL flush_calc: got %0d active cycles hi=%h lo=%h, want 0 cycles hi=%h lo=%h",
               hits, hi_o, lo_o, mdl_hi, mdl_lo);
    end
    v = '{MTHI, 32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5, mdl_lo, 3'b100, 1};
    issue(v, lat, to, nst);
    e = sb.pop_front();
    flush = 1'b1;
    #1;
    n_cmp++;
    if (to || {we_hi, we_lo, we_hilo, done_o} !== 4'b0) begin
      n_bad++;
      $display("FAIL flush_done: got we=%b done=%b to=%b, want we=000 done=0",
               {we_hi, we_lo, we_hilo}, done_o, to);
    end
    mdl_hi = e.hi;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic test_rst_mid();
    vec_t v;
    vec_t e;
    int   lat, nst;
    bit   to;
    @(posedge clk); #1;
    op = DIV; src_a = 32'hFFFF_FF9C; src_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({hi_o, lo_o, we_hi, we_lo, we_hilo, done_o, stall_o} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid: got hi=%h lo=%h we=%b done=%b stall=%b, want all 0",
               hi_o, lo_o, {we_hi, we_lo, we_hilo}, done_o, stall_o);
    end
    rst = 1'b0;
    mdl_hi = '0; mdl_lo = '0;
    v = '{DIVU, 32'd10, 32'd3, 32'd1, 32'd3, 3'b001, 33};
    issue(v, lat, to, nst);
    e = sb.pop_front();
    n_cmp++;
    if (to || {hi_o, lo_o, we_hi, we_lo, we_hilo} !== {e.hi, e.lo, e.we}
        || lat != e.lat) begin
      n_bad++;
      $display("FAIL rst_recover: got hi=%h lo=%h we=%b lat=%0d, want hi=%h lo=%h we=%b lat=%0d",
               hi_o, lo_o, {we_hi, we_lo, we_hilo}, lat, e.hi, e.lo, e.we, e.lat);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    op = 3'd7; src_a = '0; src_b = '0;
    test_reset();
    test_divide();
    test_multiply();
    test_mthi_mtlo();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
